// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the registered RISC-V datapath ALU.
//   Holds the ALUControl opcode encodings used by alu_core and by
//   any decoder that drives the ALU.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_BEQ = 3'b101;

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational result and zero-flag computation.
// Ports:
//   a, b         in   WIDTH    operands
//   alu_control  in   3        operation select (see alu_pkg)
//   result       out  WIDTH+1  computed result
//   zero         out  1        result is all zeros (forced 0 for illegal ops)
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 2
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alu_control,
    output logic [WIDTH:0]   result,
    output logic             zero
);

    logic [WIDTH:0] a_ext;
    logic [WIDTH:0] b_ext;
    logic           legal;

    always_comb begin
        a_ext  = {1'b0, a};
        b_ext  = {1'b0, b};
        result = '0;
        legal  = 1'b1;
        case (alu_control)
            OP_ADD:         result = a_ext + b_ext;
            // Borrow lands in the MSB because the difference wraps mod 2^(WIDTH+1).
            OP_SUB, OP_BEQ: result = a_ext - b_ext;
            OP_AND:         result = a_ext & b_ext;
            OP_OR:          result = a_ext | b_ext;
            OP_SLT:         result = {{WIDTH{1'b0}}, ($signed(a) < $signed(b))};
            default: begin
                result = '0;
                legal  = 1'b0;
            end
        endcase
        zero = legal && (result == '0);
    end

endmodule

// File: rtl/alu.sv
// alu: registered integer ALU for the single-cycle RISC-V datapath.
//   One-cycle latency; a new operation may be accepted every cycle.
// Ports:
//   clk         in   1        system clock, rising edge
//   rst         in   1        synchronous active-high reset
//   in_valid    in   1        A, B, ALUControl valid this cycle
//   A, B        in   WIDTH    operands
//   ALUControl  in   3        operation select
//   out_valid   out  1        ALUResult/zero hold a new result
//   ALUResult   out  WIDTH+1  registered result
//   zero        out  1        registered zero flag
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUControl,
    output logic             out_valid,
    output logic [WIDTH:0]   ALUResult,
    output logic             zero
);

    logic [WIDTH:0] core_result;
    logic           core_zero;

    logic           out_valid_q, out_valid_d;
    logic [WIDTH:0] result_q,    result_d;
    logic           zero_q,      zero_d;

    alu_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a           (A),
        .b           (B),
        .alu_control (ALUControl),
        .result      (core_result),
        .zero        (core_zero)
    );

    // Core outputs are only selected when in_valid is high, so X operands
    // on idle cycles never reach the registers.
    always_comb begin
        out_valid_d = in_valid;
        result_d    = result_q;
        zero_d      = zero_q;
        if (in_valid) begin
            result_d = core_result;
            zero_d   = core_zero;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
        end
    end

    assign out_valid = out_valid_q;
    assign ALUResult = result_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed self-checking bench for alu (WIDTH=2), plus a short
// back-to-back random run against an integer reference model.
module tb_alu;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [1:0] A;
    logic [1:0] B;
    logic [2:0] ALUControl;
    logic       out_valid;
    logic [2:0] ALUResult;
    logic       zero;

    int checks;
    int errors;

    alu #(
        .WIDTH(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .A          (A),
        .B          (B),
        .ALUControl (ALUControl),
        .out_valid  (out_valid),
        .ALUResult  (ALUResult),
        .zero       (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_out(input string tag, input logic exp_v,
                             input logic [2:0] exp_r, input logic exp_z);
        checks++;
        assert (out_valid === exp_v) else begin
            errors++;
            $error("FAIL %s out_valid got %0b expected %0b", tag, out_valid, exp_v);
        end
        checks++;
        assert (ALUResult === exp_r) else begin
            errors++;
            $error("FAIL %s ALUResult got %b expected %b", tag, ALUResult, exp_r);
        end
        checks++;
        assert (zero === exp_z) else begin
            errors++;
            $error("FAIL %s zero got %0b expected %0b", tag, zero, exp_z);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one operation, clock it in, and check the registered output.
    task automatic op(input string tag, input logic [2:0] ctl, input logic [1:0] a,
                      input logic [1:0] b, input logic [2:0] exp_r, input logic exp_z);
        in_valid   = 1'b1;
        ALUControl = ctl;
        A          = a;
        B          = b;
        step();
        check_out(tag, 1'b1, exp_r, exp_z);
    endtask

    // Reference model written with plain integer arithmetic.
    task automatic model(input logic [2:0] ctl, input logic [1:0] a, input logic [1:0] b,
                         output logic [2:0] r, output logic z);
        int ia, ib, sa, sb, v;
        ia = int'(a);
        ib = int'(b);
        sa = (ia >= 2) ? ia - 4 : ia;
        sb = (ib >= 2) ? ib - 4 : ib;
        v  = 0;
        case (ctl)
            3'd0:       v = (ia + ib) % 8;
            3'd1, 3'd5: v = (ia - ib + 8) % 8;
            3'd2:       v = ia & ib;
            3'd3:       v = ia | ib;
            3'd4:       v = (sa < sb) ? 1 : 0;
            default:    v = 0;
        endcase
        r = v[2:0];
        z = (ctl <= 3'd5) && (v == 0);
    endtask

    initial begin
        logic [2:0] exp_r;
        logic       exp_z;
        logic [2:0] rc;
        logic [1:0] ra, rb;

        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        in_valid   = 1'b1;
        ALUControl = 3'b000;
        A          = 2'b11;
        B          = 2'b11;

        // Reset wins over in_valid.
        step();
        check_out("reset_c1", 1'b0, 3'b000, 1'b0);
        step();
        check_out("reset_c2", 1'b0, 3'b000, 1'b0);
        rst = 1'b0;

        // Arithmetic; first op after reset appears one cycle later.
        op("add_01_01", 3'b000, 2'b01, 2'b01, 3'b010, 1'b0);
        op("add_11_11", 3'b000, 2'b11, 2'b11, 3'b110, 1'b0);
        op("sub_10_01", 3'b001, 2'b10, 2'b01, 3'b001, 1'b0);
        op("sub_01_10", 3'b001, 2'b01, 2'b10, 3'b111, 1'b0);
        op("sub_10_10", 3'b001, 2'b10, 2'b10, 3'b000, 1'b1);

        // Logic.
        op("and_11_01", 3'b010, 2'b11, 2'b01, 3'b001, 1'b0);
        op("or_10_01",  3'b011, 2'b10, 2'b01, 3'b011, 1'b0);
        op("and_10_01", 3'b010, 2'b10, 2'b01, 3'b000, 1'b1);

        // Compare.
        op("slt_01_10", 3'b100, 2'b01, 2'b10, 3'b000, 1'b1);
        op("slt_10_01", 3'b100, 2'b10, 2'b01, 3'b001, 1'b0);
        op("slt_11_01", 3'b100, 2'b11, 2'b01, 3'b001, 1'b0);
        op("beq_01_10", 3'b101, 2'b01, 2'b10, 3'b111, 1'b0);
        op("beq_01_01", 3'b101, 2'b01, 2'b01, 3'b000, 1'b1);

        // Illegal opcodes: zero forced low even though result is 000.
        op("ill_111", 3'b111, 2'b11, 2'b01, 3'b000, 1'b0);
        op("ill_110", 3'b110, 2'b10, 2'b10, 3'b000, 1'b0);

        // Hold: load a known nonzero result, then idle with X inputs.
        op("pre_hold", 3'b000, 2'b10, 2'b11, 3'b101, 1'b0);
        in_valid   = 1'b0;
        A          = 2'bxx;
        B          = 2'bxx;
        ALUControl = 3'bxxx;
        for (int i = 0; i < 3; i++) begin
            step();
            check_out($sformatf("hold_%0d", i), 1'b0, 3'b101, 1'b0);
        end

        // Hold with zero=1 held.
        op("pre_hold_z", 3'b001, 2'b11, 2'b11, 3'b000, 1'b1);
        in_valid = 1'b0;
        step();
        check_out("hold_z", 1'b0, 3'b000, 1'b1);

        // Back-to-back random ops, in_valid high every cycle.
        for (int i = 0; i < 16; i++) begin
            rc = 3'($urandom_range(0, 7));
            ra = 2'($urandom_range(0, 3));
            rb = 2'($urandom_range(0, 3));
            model(rc, ra, rb, exp_r, exp_z);
            op($sformatf("b2b_%0d_op%0d_%b_%b", i, rc, ra, rb), rc, ra, rb, exp_r, exp_z);
        end

        // Reset mid-stream clears outputs.
        rst = 1'b1;
        step();
        check_out("reset_late", 1'b0, 3'b000, 1'b0);
        rst      = 1'b0;
        in_valid = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
